// File: rtl/bp_be_pkg.sv
// Shared types and constants for the backend stride prefetch scheduler.
// The page-cross filter is enabled by BP_BE_PF_PAGE_CROSS_FILTER_EN.
package bp_be_pkg;

    localparam int bp_be_vaddr_width_gp = 39;
    localparam int bp_be_pf_page_offset_width_gp = 12;

    typedef enum logic [1:0] {
        e_pf_idle  = 2'd0,
        e_pf_issue = 2'd1,
        e_pf_drain = 2'd2
    } bp_be_pf_sched_state_e;

    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_be_stride_prefetch_sched_if.sv
// Loop descriptor and prefetch request/completion bundle.
// Slave side is the scheduler; master side is loop inference plus cache.
interface bp_be_stride_prefetch_sched_if #(
    parameter int vaddr_width_p  = 39,
    parameter int output_range_p = 8,
    parameter int stride_width_p = 8
);

    logic                      loop_v_i;
    logic [output_range_p-1:0] iters_i;
    logic [vaddr_width_p-1:0]  pc_i;
    logic [vaddr_width_p-1:0]  eff_addr_i;
    logic [stride_width_p-1:0] stride_i;
    logic                      loop_yumi_o;

    logic                      pf_v_o;
    logic [vaddr_width_p-1:0]  pf_vaddr_o;
    logic [vaddr_width_p-1:0]  pf_pc_o;
    logic                      pf_ready_and_i;
    logic                      pf_done_i;

    modport master (
        output loop_v_i, iters_i, pc_i, eff_addr_i, stride_i,
        input  loop_yumi_o,
        input  pf_v_o, pf_vaddr_o, pf_pc_o,
        output pf_ready_and_i, pf_done_i
    );

    modport slave (
        input  loop_v_i, iters_i, pc_i, eff_addr_i, stride_i,
        output loop_yumi_o,
        output pf_v_o, pf_vaddr_o, pf_pc_o,
        input  pf_ready_and_i, pf_done_i
    );

endinterface

// File: rtl/bsg_counter_up_down.sv
// Saturating-free up/down counter tracking in-flight prefetches.
// A decrement at zero is dropped and flagged in simulation.
module bsg_counter_up_down #(
    parameter int width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    logic down_eff;

    assign down_eff = down_i && (count_o != '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (up_i && !down_eff) begin
            count_o <= count_o + width_p'(1);
        end else if (!up_i && down_eff) begin
            count_o <= count_o - width_p'(1);
        end
    end

    done_at_zero: assert property (
        @(posedge clk_i) disable iff (reset_i)
        !(down_i && (count_o == '0))
    );

endmodule

// File: rtl/bp_be_stride_prefetch_sched.sv
// Walks a striding loop's address stream, issuing credit-limited prefetches.
// Optional BP_BE_PF_PAGE_CROSS_FILTER_EN stops issue at the base 4 KiB page.
module bp_be_stride_prefetch_sched
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p     = bp_be_vaddr_width_gp,
    parameter int output_range_p    = 8,
    parameter int stride_width_p    = 8,
    parameter int max_outstanding_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic flush_i,
    output logic busy_o,
    bp_be_stride_prefetch_sched_if.slave io
);

    localparam int cnt_w_lp =
        bsg_safe_clog2(max_outstanding_p + 1);
    localparam int ext_w_lp = vaddr_width_p - stride_width_p;
    localparam int pg_lo_lp = bp_be_pf_page_offset_width_gp;

    bp_be_pf_sched_state_e state_r, state_n;

    logic [vaddr_width_p-1:0]  addr_r;
    logic [vaddr_width_p-1:0]  pc_r;
    logic [stride_width_p-1:0] stride_r;
    logic [output_range_p-1:0] count_r, count_n;
    logic [output_range_p-1:0] init_count;
    logic [cnt_w_lp-1:0]       outstanding;

    logic [vaddr_width_p-1:0] stride_ext;
    logic [vaddr_width_p-1:0] stride_in_ext;
    logic [vaddr_width_p-1:0] next_addr;
    logic                     accept;
    logic                     credit;
    logic                     pf_v;
    logic                     hs;
    logic                     page_cross;

    assign stride_ext =
        {{ext_w_lp{stride_r[stride_width_p-1]}}, stride_r};
    assign stride_in_ext =
        {{ext_w_lp{io.stride_i[stride_width_p-1]}}, io.stride_i};
    assign next_addr = addr_r + stride_ext;

    // A zero stride would refetch the same line; issue it once at most.
    always_comb begin
        init_count = io.iters_i;
        if (io.stride_i == '0) begin
            init_count = (io.iters_i != '0)
                ? output_range_p'(1) : '0;
        end
    end

    assign accept = (state_r == e_pf_idle)
        && io.loop_v_i && !flush_i;
    assign credit = outstanding < cnt_w_lp'(max_outstanding_p);
    assign pf_v = (state_r == e_pf_issue)
        && (count_r != '0) && credit;
    assign hs = pf_v && io.pf_ready_and_i;

`ifdef BP_BE_PF_PAGE_CROSS_FILTER_EN
    logic [vaddr_width_p-1:pg_lo_lp] base_page_r;

    assign page_cross =
        next_addr[vaddr_width_p-1:pg_lo_lp] != base_page_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_page_r <= '0;
        end else if (accept) begin
            base_page_r <= io.eff_addr_i[vaddr_width_p-1:pg_lo_lp];
        end
    end
`else
    assign page_cross = 1'b0;
`endif

    always_comb begin
        state_n = state_r;
        count_n = count_r;
        unique case (state_r)
            e_pf_idle: begin
                if (accept) begin
                    count_n = init_count;
                    state_n = (init_count != '0)
                        ? e_pf_issue : e_pf_idle;
                end
            end
            e_pf_issue: begin
                if (hs) begin
                    count_n = page_cross
                        ? '0 : count_r - output_range_p'(1);
                    if (count_n == '0) begin
                        state_n = e_pf_drain;
                    end
                end
            end
            e_pf_drain: begin
                if (outstanding == '0) begin
                    state_n = e_pf_idle;
                end
            end
            default: state_n = e_pf_idle;
        endcase
        if (flush_i) begin
            state_n = e_pf_idle;
            count_n = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= e_pf_idle;
            count_r  <= '0;
            addr_r   <= '0;
            pc_r     <= '0;
            stride_r <= '0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
            if (accept) begin
                addr_r   <= io.eff_addr_i + stride_in_ext;
                pc_r     <= io.pc_i;
                stride_r <= io.stride_i;
            end else if (hs) begin
                addr_r <= next_addr;
            end
        end
    end

    // Credit survives flushes; in-flight requests still occupy the cache.
    bsg_counter_up_down #(
        .width_p(cnt_w_lp)
    ) outstanding_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .up_i   (hs),
        .down_i (io.pf_done_i),
        .count_o(outstanding)
    );

    assign io.loop_yumi_o = accept;
    assign io.pf_v_o      = pf_v;
    assign io.pf_vaddr_o  = addr_r;
    assign io.pf_pc_o     = pc_r;
    assign busy_o         = (state_r != e_pf_idle);

endmodule

// File: tb/tb_bp_be_stride_prefetch_sched.sv
// Directed and randomized checks of the stride prefetch scheduler
// against a queue-based model of the issued address stream.
module tb_bp_be_stride_prefetch_sched;

    localparam int VA   = 39;
    localparam int MAXO = 4;

    logic clk;
    logic rst;
    logic fl;
    logic busy;
    bit   want_done;

    int n_tests;
    int n_fail;
    int cyc;
    int acc_cyc;

    logic [VA-1:0] m_q[$];
    logic [VA-1:0] m_pc;
    bit            m_busy;
    int            m_out;
    logic [VA-1:0] log_q[$];
    int            hs_cyc[$];

    bp_be_stride_prefetch_sched_if #(
        .vaddr_width_p (VA),
        .output_range_p(8),
        .stride_width_p(8)
    ) bus ();

    bp_be_stride_prefetch_sched #(
        .vaddr_width_p    (VA),
        .output_range_p   (8),
        .stride_width_p   (8),
        .max_outstanding_p(MAXO)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .flush_i(fl),
        .busy_o (busy),
        .io     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs,
                         logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Expected stream: eff + k*stride for k = 1..n, modulo 2^VA.
    function automatic void load();
        int st;
        int n;
        logic [VA-1:0] a;
        logic [VA-1:0] e;
        e  = bus.eff_addr_i;
        st = int'($signed(bus.stride_i));
        n  = (bus.stride_i == 8'd0)
            ? ((bus.iters_i != 8'd0) ? 1 : 0)
            : int'(bus.iters_i);
        m_q.delete();
        m_pc = bus.pc_i;
        for (int k = 1; k <= n; k++) begin
            a = e + VA'(longint'(k) * longint'(st));
`ifdef BP_BE_PF_PAGE_CROSS_FILTER_EN
            if (k > 1 && a[VA-1:12] != e[VA-1:12]) break;
`endif
            m_q.push_back(a);
        end
        m_busy = (m_q.size() > 0);
    endfunction

    task automatic tick();
        bit e_yumi;
        bit e_pfv;
        bit e_hs;
        bit qe;
        bit d;
        int o;
        bus.pf_done_i = want_done && (m_out > 0) && !rst;
        #2;
        qe     = (m_q.size() == 0);
        e_yumi = !m_busy && bus.loop_v_i && !fl;
        e_pfv  = !qe && (m_out < MAXO);
        if (!rst) begin
            check("yumi", bus.loop_yumi_o, e_yumi);
            check("pf_v", bus.pf_v_o, e_pfv);
            check("busy", busy, m_busy);
            if (e_pfv && bus.pf_v_o) begin
                check("vaddr", bus.pf_vaddr_o, m_q[0]);
                check("pc", bus.pf_pc_o, m_pc);
            end
        end
        if (bus.loop_v_i && bus.loop_yumi_o) acc_cyc = cyc;
        if (bus.pf_v_o && bus.pf_ready_and_i) begin
            log_q.push_back(bus.pf_vaddr_o);
            hs_cyc.push_back(cyc);
        end
        e_hs = e_pfv && bus.pf_ready_and_i;
        d    = bus.pf_done_i;
        o    = m_out;
        if (rst) begin
            m_busy = 1'b0;
            m_q.delete();
            m_out = 0;
        end else begin
            if (e_hs) void'(m_q.pop_front());
            m_out = m_out + int'(e_hs) - int'(d);
            if (fl) begin
                m_busy = 1'b0;
                m_q.delete();
            end else if (e_yumi) begin
                load();
            end else if (m_busy && qe && o == 0) begin
                m_busy = 1'b0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(logic [VA-1:0] e, logic [7:0] s,
                        logic [7:0] it);
        bus.loop_v_i   = 1'b1;
        bus.eff_addr_i = e;
        bus.stride_i   = s;
        bus.iters_i    = it;
        bus.pc_i       = e ^ VA'(39'h40_0000_0400);
        tick();
        bus.loop_v_i = 1'b0;
    endtask

    task automatic wait_idle(string tag);
        want_done = 1'b1;
        for (int i = 0; i < 200 && (busy || m_busy || m_out > 0);
             i++) begin
            tick();
        end
        check(tag, busy, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        acc_cyc = -1;
        m_busy  = 1'b0;
        m_out   = 0;
        m_pc    = '0;
        rst     = 1'b1;
        fl      = 1'b0;
        want_done = 1'b0;
        bus.loop_v_i       = 1'b0;
        bus.iters_i        = '0;
        bus.pc_i           = '0;
        bus.eff_addr_i     = '0;
        bus.stride_i       = '0;
        bus.pf_ready_and_i = 1'b1;
        bus.pf_done_i      = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("rst_pf_v", bus.pf_v_o, 1'b0);
        check("rst_yumi", bus.loop_yumi_o, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_vaddr", bus.pf_vaddr_o, 0);
        check("rst_pc", bus.pf_pc_o, 0);

        // basic run with immediate completions
        want_done = 1'b1;
        log_q.delete();
        hs_cyc.delete();
        send(VA'(39'h1000), 8'd8, 8'd3);
        wait_idle("basic_idle");
        check("basic_cnt", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("basic_a0", log_q[0], 39'h1008);
            check("basic_a1", log_q[1], 39'h1010);
            check("basic_a2", log_q[2], 39'h1018);
            check("basic_first", hs_cyc[0], acc_cyc + 1);
            check("basic_rate", hs_cyc[2] - hs_cyc[0], 2);
        end

        // credit limit
        want_done = 1'b0;
        log_q.delete();
        send(VA'(39'h3000), 8'd4, 8'd10);
        repeat (10) tick();
        check("credit_hs", log_q.size(), MAXO);
        check("credit_pfv", bus.pf_v_o, 1'b0);
        want_done = 1'b1;
        tick();
        want_done = 1'b0;
        repeat (5) tick();
        check("credit_one_more", log_q.size(), MAXO + 1);
        wait_idle("credit_idle");

        // negative stride
        log_q.delete();
        send(VA'(39'h2000), 8'hF0, 8'd2);
        wait_idle("neg_idle");
`ifdef BP_BE_PF_PAGE_CROSS_FILTER_EN
        check("neg_cnt", log_q.size(), 1);
`else
        check("neg_cnt", log_q.size(), 2);
        if (log_q.size() == 2) check("neg_a1", log_q[1], 39'h1FE0);
`endif
        if (log_q.size() > 0) check("neg_a0", log_q[0], 39'h1FF0);

        // zero stride issues once
        log_q.delete();
        send(VA'(39'h8000), 8'd0, 8'd5);
        wait_idle("zs_idle");
        check("zs_cnt", log_q.size(), 1);
        if (log_q.size() > 0) check("zs_a0", log_q[0], 39'h8000);

        // zero iterations
        log_q.delete();
        send(VA'(39'hA000), 8'd8, 8'd0);
        check("zi_busy", busy, 1'b0);
        repeat (3) tick();
        check("zi_cnt", log_q.size(), 0);

        // page boundary
        log_q.delete();
        send(VA'(39'h1FF0), 8'd8, 8'd4);
        wait_idle("page_idle");
`ifdef BP_BE_PF_PAGE_CROSS_FILTER_EN
        check("page_cnt", log_q.size(), 1);
`else
        check("page_cnt", log_q.size(), 4);
        if (log_q.size() == 4) check("page_a3", log_q[3], 39'h2010);
`endif
        if (log_q.size() > 0) check("page_a0", log_q[0], 39'h1FF8);

        // flush after two requests, then new loop on shared credit
        want_done = 1'b0;
        log_q.delete();
        send(VA'(39'h5000), 8'h10, 8'd6);
        for (int i = 0; i < 20 && log_q.size() < 2; i++) tick();
        bus.pf_ready_and_i = 1'b0;
        fl = 1'b1;
        tick();
        fl = 1'b0;
        bus.pf_ready_and_i = 1'b1;
        check("flush_busy", busy, 1'b0);
        check("flush_pfv", bus.pf_v_o, 1'b0);
        check("flush_hs", log_q.size(), 2);
        log_q.delete();
        send(VA'(39'h6000), 8'd8, 8'd6);
        repeat (8) tick();
        check("flush_credit", log_q.size(), 2);
        wait_idle("flush_idle");
        check("flush_total", log_q.size(), 6);
        if (log_q.size() == 6) check("flush_last", log_q[5], 39'h6030);

        // reset mid-issue
        want_done = 1'b0;
        send(VA'(39'h7000), 8'd4, 8'd8);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_pfv", bus.pf_v_o, 1'b0);
        check("mrst_vaddr", bus.pf_vaddr_o, 0);
        check("mrst_pc", bus.pf_pc_o, 0);
        check("mrst_busy", busy, 1'b0);
        log_q.delete();
        send(VA'(39'h7100), 8'd4, 8'd8);
        repeat (10) tick();
        check("mrst_credit", log_q.size(), MAXO);
        wait_idle("mrst_idle");

        // handshake and completion in the same cycle
        want_done = 1'b0;
        log_q.delete();
        send(VA'(39'h9000), 8'd4, 8'd8);
        for (int i = 0; i < 20 && log_q.size() < 2; i++) tick();
        want_done = 1'b1;
        tick();
        want_done = 1'b0;
        repeat (8) tick();
        check("simul_hs", log_q.size(), 5);
        wait_idle("simul_idle");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.loop_v_i       = ($urandom_range(0, 2) == 0);
            bus.eff_addr_i     = VA'({$urandom(), $urandom()});
            bus.stride_i       = 8'($urandom());
            bus.iters_i        = 8'($urandom_range(0, 12));
            bus.pc_i           = VA'({$urandom(), $urandom()});
            bus.pf_ready_and_i = ($urandom_range(0, 3) != 0);
            want_done          = ($urandom_range(0, 1) == 1);
            fl                 = ($urandom_range(0, 39) == 0);
            rst                = ($urandom_range(0, 299) == 0);
            tick();
        end
        bus.loop_v_i       = 1'b0;
        bus.pf_ready_and_i = 1'b1;
        fl                 = 1'b0;
        rst                = 1'b0;
        wait_idle("rand_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
